alu_sched: RTL and testbench

- Shares the single combinational `alu` between two requesters and sequences each operation through it.
  - Requester 0: main execute datapath.
  - Requester 1: branch/address unit.
- Arbitrates round-robin, latches the operands, drives the ALU for exactly one cycle, registers result and zero flag, and returns them with a requester tag.
- Sits between the decode/issue logic and the `alu` instance in the CPU.

---
 rtl/alu_sched.sv | 102 ++++++++++
 tb/tb_alu_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: round-robin sharer of one combinational alu between two requesters; ALU_SCHED_STATS_EN adds grant counters
module alu_sched #(
    parameter int DW      = 32,
    parameter bit RR_INIT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_instr,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_instr,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic [DW-1:0] alu_instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_id,
    output logic [DW-1:0] resp_result,
    output logic          resp_zero,
    output logic          busy,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t        state, state_nx;
    logic          last_id, id, grant, hs;
    logic [DW-1:0] op, a, b;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (hs ? EXEC : IDLE) :
                   state == EXEC ? RESP :
                   (resp_ready ? IDLE : RESP);
    end

    always_comb begin
        grant      = (req0_valid && req1_valid) ? !last_id : req1_valid;
        req0_ready = state == IDLE && req0_valid && !grant;
        req1_ready = state == IDLE && req1_valid && grant;
        hs         = req0_ready || req1_ready;
        busy       = state != IDLE;
        alu_instr  = op;
        alu_a      = a;
        alu_b      = b;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            last_id     <= RR_INIT;
            id          <= 1'b0;
            op          <= '0;
            a           <= '0;
            b           <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            if (hs) begin
                op      <= grant ? req1_instr : req0_instr;
                a       <= grant ? req1_a : req0_a;
                b       <= grant ? req1_b : req0_b;
                id      <= grant;
                last_id <= grant;
            end
            if (state == EXEC) begin
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
                resp_id     <= id;
                resp_valid  <= 1'b1;
            end
            if (state == RESP && resp_ready) resp_valid <= 1'b0;
        end

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] cnt0, cnt1;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (req0_ready && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (req1_ready && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    assign grant_cnt0 = cnt0;
    assign grant_cnt1 = cnt1;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized self-checking bench for alu_sched with a behavioural alu and scheduler model
module tb_alu_sched;
    logic        clk = 0, rst = 0;
    logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [31:0] req0_instr = 0, req0_a = 0, req0_b = 0;
    logic [31:0] req1_instr = 0, req1_a = 0, req1_b = 0;
    logic [31:0] alu_instr, alu_a, alu_b, alu_result, resp_result;
    logic        alu_zero, resp_valid, resp_ready = 0, resp_id, resp_zero, busy;
    logic [15:0] grant_cnt0, grant_cnt1;
    int total = 0, bad = 0;
    bit m_last = 1;
    int m_cnt0 = 0, m_cnt1 = 0;

    alu_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr), .req1_a(req1_a), .req1_b(req1_b),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero), .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_f(input logic [31:0] ins, input logic [31:0] x, input logic [31:0] y);
        logic [5:0] opc;
        opc = ins[31:26];
        if (opc == 6'd0)
            case (ins[5:0])
                6'h20, 6'h21: return {1'b0, x + y};
                6'h22, 6'h23: return {1'b0, x - y};
                6'h24:        return {1'b0, x & y};
                6'h25:        return {1'b0, x | y};
                default:      return {1'b0, 32'hDEADBEEF};
            endcase
        if (opc == 6'd4) return {x == y, x - y};
        if (opc == 6'd5) return {x != y, x - y};
        return {1'b0, x ^ y};
    endfunction

    always_comb {alu_zero, alu_result} = alu_f(alu_instr, alu_a, alu_b);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1;
        tick();
        rst = 0;
        m_last = 1;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    task automatic drive(input bit r, input bit v, input logic [31:0] ins, input logic [31:0] x, input logic [31:0] y);
        if (r) begin req1_valid = v; req1_instr = ins; req1_a = x; req1_b = y; end
        else   begin req0_valid = v; req0_instr = ins; req0_a = x; req0_b = y; end
    endtask

    task automatic run_op(input bit r, input logic [31:0] ins, input logic [31:0] x, input logic [31:0] y,
                          output bit rdy, output bit early, output bit v, output bit rid,
                          output logic [31:0] res, output bit z);
        drive(r, 1, ins, x, y);
        #1;
        rdy = r ? (req1_ready && !req0_ready) : (req0_ready && !req1_ready);
        if (rdy) begin
            m_last = r;
            if (r) m_cnt1++; else m_cnt0++;
        end
        tick();
        drive(r, 0, 0, 0, 0);
        early = resp_valid;
        tick();
        v = resp_valid; rid = resp_id; res = resp_result; z = resp_zero;
        resp_ready = 1;
        tick();
        resp_ready = 0;
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if ({resp_valid, resp_id, resp_result, resp_zero, busy, alu_instr, alu_a, alu_b} !== '0) begin
            bad++; $display("FAIL reset_outputs got v=%b id=%b r=%h z=%b busy=%b ai=%h aa=%h ab=%h want all 0",
                resp_valid, resp_id, resp_result, resp_zero, busy, alu_instr, alu_a, alu_b);
        end
        total++;
        if ({req0_ready, req1_ready, grant_cnt0, grant_cnt1} !== '0) begin
            bad++; $display("FAIL reset_ready got r0=%b r1=%b c0=%0d c1=%0d want 0", req0_ready, req1_ready, grant_cnt0, grant_cnt1);
        end
    endtask

    task automatic test_add;
        bit rdy, early, v, rid, z; logic [31:0] res;
        run_op(0, 32'h00000020, 5, 7, rdy, early, v, rid, res, z);
        total++;
        if ({rdy, early, v} !== 3'b101) begin
            bad++; $display("FAIL add_timing got rdy=%b early=%b valid=%b want 1 0 1", rdy, early, v);
        end
        total++;
        if ({rid, res, z} !== {1'b0, 32'd12, 1'b0}) begin
            bad++; $display("FAIL add_resp got id=%b res=%0d z=%b want 0 12 0", rid, res, z);
        end
    endtask

    task automatic test_beq;
        bit rdy, early, v, rid, z; logic [31:0] res;
        run_op(1, 32'h10000000, 3, 3, rdy, early, v, rid, res, z);
        total++;
        if ({rdy, v, rid, res, z} !== {3'b111, 32'd0, 1'b1}) begin
            bad++; $display("FAIL beq_eq got rdy=%b v=%b id=%b res=%h z=%b want 1 1 1 0 1", rdy, v, rid, res, z);
        end
        run_op(1, 32'h10000000, 3, 4, rdy, early, v, rid, res, z);
        total++;
        if ({rdy, v, rid, z} !== 4'b1110) begin
            bad++; $display("FAIL beq_ne got rdy=%b v=%b id=%b z=%b want 1 1 1 0", rdy, v, rid, z);
        end
    endtask

    task automatic test_round_robin;
        bit g;
        do_reset();
        drive(0, 1, 32'h00000021, 1, 1);
        drive(1, 1, 32'h00000022, 9, 4);
        resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            g = i[0];
            #1;
            total++;
            if ({req0_ready, req1_ready} !== {!g, g}) begin
                bad++; $display("FAIL rr_grant op=%0d got r0=%b r1=%b want grant %0d", i, req0_ready, req1_ready, g);
            end
            if (g) m_cnt1++; else m_cnt0++;
            m_last = g;
            tick();
            total++;
            if ({req0_ready, req1_ready, busy} !== 3'b001) begin
                bad++; $display("FAIL rr_exec op=%0d got r0=%b r1=%b busy=%b want 0 0 1", i, req0_ready, req1_ready, busy);
            end
            tick();
            total++;
            if ({resp_valid, resp_id, resp_result} !== {1'b1, g, g ? 32'd5 : 32'd2}) begin
                bad++; $display("FAIL rr_resp op=%0d got v=%b id=%b res=%0d want 1 %0d %0d", i, resp_valid, resp_id, resp_result, g, g ? 5 : 2);
            end
            tick();
        end
        resp_ready = 0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure;
        logic [31:0] r;
        drive(0, 1, 32'h00000022, 100, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        m_cnt0++; m_last = 0;
        tick();
        r = 32'd99;
        drive(0, 1, 32'h00000020, 1, 2);
        drive(1, 1, 32'h00000020, 3, 4);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({resp_valid, resp_id, resp_result, resp_zero, busy, req0_ready, req1_ready} !== {2'b10, r, 4'b0100}) begin
                bad++; $display("FAIL bp_hold cyc=%0d got v=%b id=%b res=%0d z=%b busy=%b r0=%b r1=%b want 1 0 99 0 1 0 0",
                    i, resp_valid, resp_id, resp_result, resp_zero, busy, req0_ready, req1_ready);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        resp_ready = 1;
        tick();
        resp_ready = 0;
        total++;
        if ({busy, resp_valid, resp_result} !== {2'b00, r}) begin
            bad++; $display("FAIL bp_release got busy=%b v=%b res=%0d want 0 0 99", busy, resp_valid, resp_result);
        end
    endtask

    task automatic test_reset_exec;
        drive(1, 1, 32'h00000020, 8, 8);
        tick();
        drive(1, 0, 0, 0, 0);
        rst = 1;
        #1;
        total++;
        if ({resp_valid, resp_id, resp_result, resp_zero, busy, alu_instr, alu_a, alu_b} !== '0) begin
            bad++; $display("FAIL rst_exec_out got v=%b busy=%b res=%h ai=%h want all 0", resp_valid, busy, resp_result, alu_instr);
        end
        tick();
        rst = 0;
        m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
        tick();
        total++;
        if ({resp_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL rst_exec_noresp got v=%b busy=%b want 0 0", resp_valid, busy);
        end
        drive(0, 1, 32'h00000020, 1, 1);
        drive(1, 1, 32'h00000020, 1, 1);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL rst_exec_first got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_random;
        bit v0, v1, eg, er0, er1;
        logic [31:0] ins [2], xa [2], xb [2], eres;
        logic [32:0] e;
        int hold;
        for (int n = 0; n < 200; n++) begin
            v0 = $urandom_range(0, 3) != 0;
            v1 = $urandom_range(0, 3) != 0;
            for (int r = 0; r < 2; r++) begin
                case ($urandom_range(0, 5))
                    0: ins[r] = 32'h00000020;
                    1: ins[r] = 32'h00000022;
                    2: ins[r] = 32'h00000024;
                    3: ins[r] = 32'h10000000;
                    4: ins[r] = 32'h14000000;
                    default: ins[r] = $urandom;
                endcase
                xa[r] = $urandom_range(0, 3) == 0 ? 32'd7 : $urandom;
                xb[r] = $urandom_range(0, 1) == 0 ? xa[r] : $urandom;
            end
            drive(0, v0, ins[0], xa[0], xb[0]);
            drive(1, v1, ins[1], xa[1], xb[1]);
            eg = (v0 && v1) ? !m_last : v1;
            er0 = v0 && !eg;
            er1 = v1 && eg;
            #1;
            total++;
            if ({req0_ready, req1_ready} !== {er0, er1}) begin
                bad++; $display("FAIL rnd_grant n=%0d got r0=%b r1=%b want %b %b", n, req0_ready, req1_ready, er0, er1);
            end
            tick();
            if (!(v0 || v1)) continue;
            m_last = eg;
            if (eg) m_cnt1++; else m_cnt0++;
            e = alu_f(ins[eg], xa[eg], xb[eg]);
            eres = e[31:0];
            drive(0, $urandom_range(0, 1), $urandom, $urandom, $urandom);
            drive(1, $urandom_range(0, 1), $urandom, $urandom, $urandom);
            tick();
            hold = $urandom_range(0, 2);
            for (int h = 0; h <= hold; h++) begin
                total++;
                if ({resp_valid, resp_id, resp_result, resp_zero, busy, req0_ready, req1_ready} !== {1'b1, eg, eres, e[32], 3'b100}) begin
                    bad++; $display("FAIL rnd_resp n=%0d got v=%b id=%b res=%h z=%b busy=%b r0=%b r1=%b want 1 %b %h %b 1 0 0",
                        n, resp_valid, resp_id, resp_result, resp_zero, busy, req0_ready, req1_ready, eg, eres, e[32]);
                end
                resp_ready = h == hold;
                tick();
            end
            resp_ready = 0;
            drive(0, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0);
            total++;
            if ({busy, resp_valid} !== 2'b00) begin
                bad++; $display("FAIL rnd_idle n=%0d got busy=%b v=%b want 0 0", n, busy, resp_valid);
            end
        end
    endtask

    task automatic test_stats;
        bit rdy, early, v, rid, z; logic [31:0] res;
        int e0, e1;
        do_reset();
        for (int i = 0; i < 5; i++) run_op(i >= 3, 32'h00000020, i, 1, rdy, early, v, rid, res, z);
`ifdef ALU_SCHED_STATS_EN
        e0 = m_cnt0; e1 = m_cnt1;
`else
        e0 = 0; e1 = 0;
`endif
        total++;
        if (grant_cnt0 !== 16'(e0) || grant_cnt1 !== 16'(e1)) begin
            bad++; $display("FAIL stats got c0=%0d c1=%0d want %0d %0d", grant_cnt0, grant_cnt1, e0, e1);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_beq();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_random();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
